// File: rtl/karnaugh_pkg.sv
// Shared definitions for the K-map sweep characteriser: state encoding,
// problem dimensions and the default expected SOP minterm mask.
package karnaugh_pkg;

    localparam int N_VARS     = 4;
    localparam int N_MINTERMS = 16;

    // Truth table of the reference SOP/POS K-map function, bit i = f(i).
    localparam logic [N_MINTERMS-1:0] SOP_MASK = 16'h5057;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/karnaugh_settle_timer.sv
// Loadable 4-bit down-counter that measures how long each stimulus vector
// is held before the function output is sampled.
module karnaugh_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_r;

    // Load has priority over decrement; otherwise the count holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/karnaugh_sweep.sv
// Sweeps a 4-input combinational function through all 16 input codes,
// rebuilds its truth table, counts the ON-set and compares it against an
// expected mask. Every output is registered.
module karnaugh_sweep
    import karnaugh_pkg::*;
#(
    parameter int                    SETTLE = 1,
    parameter logic [N_MINTERMS-1:0] EXPECT = SOP_MASK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  x1,
    output logic                  x2,
    output logic                  x3,
    output logic                  x4,
    input  logic                  f_in,
    output logic                  busy,
    output logic                  done,
    output logic [N_MINTERMS-1:0] minterms,
    output logic [4:0]            count,
    output logic                  match
);

    localparam logic [N_VARS-1:0] LAST_IDX   = 4'(N_MINTERMS - 1);
    localparam logic [3:0]        SETTLE_VAL = 4'(SETTLE);

    state_t                  state_r;
    logic [N_VARS-1:0]       idx_r;
    logic [N_VARS-1:0]       x_r;
    logic                    busy_r;
    logic                    done_r;
    logic [N_MINTERMS-1:0]   minterms_r;
    logic [4:0]              count_r;
    logic                    match_r;

    logic                    abort_s;
    logic                    tmr_load_s;
    logic                    tmr_dec_s;
    logic                    tmr_zero_s;

    // Abort only matters once a sweep is under way.
    assign abort_s = abort && (state_r != ST_IDLE);

    // Timer control: reload when a vector is presented, count down while settling.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        if (abort_s) begin
            tmr_load_s = 1'b0;
            tmr_dec_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:   tmr_load_s = start;
                ST_SETTLE: tmr_dec_s  = !tmr_zero_s;
                ST_SAMPLE: tmr_load_s = (idx_r != LAST_IDX);
                ST_DONE:   tmr_load_s = 1'b0;
                default:   tmr_load_s = 1'b0;
            endcase
        end
    end

    karnaugh_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (SETTLE_VAL),
        .dec      (tmr_dec_s),
        .zero     (tmr_zero_s)
    );

    // Sweep FSM with index, stimulus and capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= 4'd0;
            x_r        <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            minterms_r <= 16'h0000;
            count_r    <= 5'd0;
            match_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort_s) begin
                // Cancelled sweeps leave no partial result behind.
                state_r    <= ST_IDLE;
                idx_r      <= 4'd0;
                x_r        <= 4'd0;
                busy_r     <= 1'b0;
                minterms_r <= 16'h0000;
                count_r    <= 5'd0;
                match_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            state_r    <= ST_SETTLE;
                            idx_r      <= 4'd0;
                            x_r        <= 4'd0;
                            busy_r     <= 1'b1;
                            minterms_r <= 16'h0000;
                            count_r    <= 5'd0;
                            match_r    <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        if (tmr_zero_s) begin
                            state_r <= ST_SAMPLE;
                        end
                    end
                    ST_SAMPLE: begin
                        minterms_r[idx_r] <= f_in;
                        count_r           <= count_r + {4'b0000, f_in};
                        if (idx_r == LAST_IDX) begin
                            state_r <= ST_DONE;
                        end else begin
                            idx_r   <= idx_r + 4'd1;
                            x_r     <= idx_r + 4'd1;
                            state_r <= ST_SETTLE;
                        end
                    end
                    ST_DONE: begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        match_r <= (minterms_r == EXPECT);
                        x_r     <= 4'd0;
                        idx_r   <= 4'd0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        x_r     <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign {x1, x2, x3, x4} = x_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign minterms = minterms_r;
    assign count    = count_r;
    assign match    = match_r;

endmodule

// File: tb/tb_karnaugh_sweep.sv
// Directed bench for karnaugh_sweep: one instance with SETTLE=1 driven by a
// mask-described function, one with SETTLE=0 whose f_in is its own x4.
module tb_karnaugh_sweep;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        f_in;
    logic        x1, x2, x3, x4;
    logic        busy, done, match;
    logic [15:0] minterms;
    logic [4:0]  count;
    logic [15:0] fmask;
    logic [3:0]  xv;

    logic        start0, abort0;
    logic        y1, y2, y3, y4;
    logic        busy0, done0, match0;
    logic [15:0] minterms0;
    logic [4:0]  count0;
    logic [3:0]  yv;

    int n_cmp;
    int n_bad;

    karnaugh_sweep #(.SETTLE(1), .EXPECT(16'h5057)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .f_in(f_in),
        .busy(busy), .done(done), .minterms(minterms), .count(count), .match(match)
    );

    karnaugh_sweep #(.SETTLE(0), .EXPECT(16'h5057)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .x1(y1), .x2(y2), .x3(y3), .x4(y4), .f_in(y4),
        .busy(busy0), .done(done0), .minterms(minterms0), .count(count0), .match(match0)
    );

    assign xv   = {x1, x2, x3, x4};
    assign yv   = {y1, y2, y3, y4};
    assign f_in = fmask[xv];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep on dut; k counts edges after the start edge. Optionally
    // re-pulses start at edge offset restart_at to show it is ignored.
    task automatic sweep1(input int restart_at, output int lat, output int hold_bad);
        int k;
        lat      = -1;
        hold_bad = 0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        k     = 0;
        if (xv !== 4'd0) hold_bad++;
        while (k < 200) begin
            start = (k == restart_at) ? 1'b1 : 1'b0;
            tick();
            k++;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (k <= 47 && xv !== 4'(k / 3)) hold_bad++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0;
        fmask = 16'h5057;
        #2;
        n_cmp++;
        if ({busy, done, match, xv} !== 7'd0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000000", {busy, done, match, xv});
        end
        n_cmp++;
        if ({minterms, count} !== 21'd0) begin
            n_bad++; $display("FAIL reset_data: got %h/%0d want 0000/0", minterms, count);
        end
        n_cmp++;
        if ({busy0, done0, match0, yv, minterms0, count0} !== 28'd0) begin
            n_bad++; $display("FAIL reset_dut0: outputs not all zero");
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_pos_sweep();
        int lat, hb;
        fmask = 16'h5057;
        sweep1(-1, lat, hb);
        n_cmp++;
        if (lat !== 49) begin n_bad++; $display("FAIL pos_latency: got %0d want 49", lat); end
        n_cmp++;
        if (hb !== 0) begin n_bad++; $display("FAIL pos_hold: got %0d bad cycles want 0", hb); end
        n_cmp++;
        if (minterms !== 16'h5057) begin n_bad++; $display("FAIL pos_mask: got %h want 5057", minterms); end
        n_cmp++;
        if (count !== 5'd7) begin n_bad++; $display("FAIL pos_count: got %0d want 7", count); end
        n_cmp++;
        if (match !== 1'b1) begin n_bad++; $display("FAIL pos_match: got %b want 1", match); end
        n_cmp++;
        if ({busy, xv} !== 5'd0) begin n_bad++; $display("FAIL pos_done_ctrl: got %b want 00000", {busy, xv}); end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL pos_done_width: got %b want 0", done); end
        n_cmp++;
        if ({minterms, count, match} !== {16'h5057, 5'd7, 1'b1}) begin
            n_bad++; $display("FAIL pos_hold_idle: got %h/%0d/%b want 5057/7/1", minterms, count, match);
        end
    endtask

    task automatic test_const();
        int lat, hb;
        fmask = 16'h0000;
        sweep1(-1, lat, hb);
        n_cmp++;
        if ({minterms, count, match} !== {16'h0000, 5'd0, 1'b0}) begin
            n_bad++; $display("FAIL const0: got %h/%0d/%b want 0000/0/0", minterms, count, match);
        end
        tick();
        fmask = 16'hFFFF;
        sweep1(-1, lat, hb);
        n_cmp++;
        if (lat !== 49) begin n_bad++; $display("FAIL const1_latency: got %0d want 49", lat); end
        n_cmp++;
        if (minterms !== 16'hFFFF) begin n_bad++; $display("FAIL const1_mask: got %h want ffff", minterms); end
        n_cmp++;
        if (count !== 5'd16) begin n_bad++; $display("FAIL const1_count: got %0d want 16", count); end
        n_cmp++;
        if (match !== 1'b0) begin n_bad++; $display("FAIL const1_match: got %b want 0", match); end
        tick();
    endtask

    task automatic test_settle0();
        int k, lat, hb;
        lat = -1; hb = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        k = 0;
        if (yv !== 4'd0) hb++;
        while (k < 200) begin
            tick();
            k++;
            if (done0 === 1'b1) begin lat = k; break; end
            if (k <= 31 && yv !== 4'(k / 2)) hb++;
        end
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL s0_latency: got %0d want 33", lat); end
        n_cmp++;
        if (hb !== 0) begin n_bad++; $display("FAIL s0_hold: got %0d bad cycles want 0", hb); end
        n_cmp++;
        if ({minterms0, count0, match0} !== {16'hAAAA, 5'd8, 1'b0}) begin
            n_bad++; $display("FAIL s0_result: got %h/%0d/%b want aaaa/8/0", minterms0, count0, match0);
        end
        tick();
    endtask

    task automatic test_abort();
        int seen;
        fmask = 16'h5057;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if ({minterms, count} !== {16'h0007, 5'd3}) begin
            n_bad++; $display("FAIL abort_partial: got %h/%0d want 0007/3", minterms, count);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        n_cmp++;
        if ({busy, done, xv} !== 6'd0) begin
            n_bad++; $display("FAIL abort_ctrl: got %b want 000000", {busy, done, xv});
        end
        n_cmp++;
        if ({minterms, count, match} !== 22'd0) begin
            n_bad++; $display("FAIL abort_clear: got %h/%0d/%b want 0000/0/0", minterms, count, match);
        end
        seen = 0;
        repeat (60) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen); end
        test_pos_sweep();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({minterms, count, match, busy} !== {16'h5057, 5'd7, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL abort_idle: got %h/%0d/%b/%b want 5057/7/1/0", minterms, count, match, busy);
        end
    endtask

    task automatic test_rst_mid();
        int k;
        fmask = 16'h5057;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (xv !== 4'd6 && k < 100) begin
            tick();
            k++;
        end
        n_cmp++;
        if ({k, minterms, count} !== {32'd18, 16'h0017, 5'd4}) begin
            n_bad++; $display("FAIL rst_pre: got %0d/%h/%0d want 18/0017/4", k, minterms, count);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, match, xv, minterms, count} !== 28'd0) begin
            n_bad++; $display("FAIL rst_async: got %b/%h/%0d want all 0", {busy, done, match, xv}, minterms, count);
        end
        tick();
        rst = 1'b0;
        k = 0;
        repeat (5) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) k++;
        end
        n_cmp++;
        if (k !== 0) begin n_bad++; $display("FAIL rst_no_done: got %0d active cycles want 0", k); end
    endtask

    task automatic test_back_to_back();
        int lat, hb;
        fmask = 16'h5057;
        sweep1(20, lat, hb);
        n_cmp++;
        if (lat !== 49) begin n_bad++; $display("FAIL b2b_latency: got %0d want 49", lat); end
        n_cmp++;
        if (hb !== 0) begin n_bad++; $display("FAIL b2b_hold: got %0d bad cycles want 0", hb); end
        n_cmp++;
        if ({minterms, count, match} !== {16'h5057, 5'd7, 1'b1}) begin
            n_bad++; $display("FAIL b2b_result: got %h/%0d/%b want 5057/7/1", minterms, count, match);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_pos_sweep();
        tick();
        test_const();
        test_settle0();
        test_abort();
        tick();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
